// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared states, key codes and operator codes for the calculator entry path
//
// Optional build macro: CALC_BACKSPACE_EN (consumed by calc_key_class).
package calc_pkg;

    typedef enum logic [2:0] {
        S_A     = 3'd0,  // entering operand A
        S_OP    = 3'd1,  // operator latched, waiting for first B digit
        S_B     = 3'd2,  // entering operand B
        S_ISSUE = 3'd3,  // offering A/op/B to the ALU
        S_WAIT  = 3'd4,  // waiting for the ALU result
        S_DONE  = 3'd5   // result shown in A
    } state_t;

    localparam logic [3:0] KEY_OP1 = 4'hA;
    localparam logic [3:0] KEY_OP2 = 4'hB;
    localparam logic [3:0] KEY_OP3 = 4'hE;
    localparam logic [3:0] KEY_OP4 = 4'hF;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_EQU = 4'hD;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_1    = 3'd1;
    localparam logic [2:0] OP_2    = 3'd2;
    localparam logic [2:0] OP_3    = 3'd3;
    localparam logic [2:0] OP_4    = 3'd4;

endpackage

// File: rtl/calc_key_class.sv
// rtl/calc_key_class.sv - combinational classifier of a keypad code into key classes
//
// Ports:
//   key_code  in  4-bit decoded key
//   is_digit  out key is 0-9
//   is_op     out key is an enabled operator key
//   op_code   out operator number 1..NUM_OPS, 0 when not an enabled operator
//   is_clr    out clear key
//   is_equ    out equals key
//   is_bksp   out backspace key (only when CALC_BACKSPACE_EN is defined)
//
// Optional build macro: CALC_BACKSPACE_EN turns 0xF into backspace and clamps
// the operator count to 3.
module calc_key_class
    import calc_pkg::*;
#(
    parameter int NUM_OPS = 2
) (
    input  logic [3:0] key_code,
    output logic       is_digit,
    output logic       is_op,
    output logic [2:0] op_code,
    output logic       is_clr,
    output logic       is_equ,
    output logic       is_bksp
);

`ifdef CALC_BACKSPACE_EN
    localparam int EFF_OPS = (NUM_OPS > 3) ? 3 : NUM_OPS;
`else
    localparam int EFF_OPS = NUM_OPS;
`endif

    logic [2:0] op_num;

    always_comb begin
        op_num  = OP_NONE;
        is_bksp = 1'b0;
        case (key_code)
            KEY_OP1: op_num = OP_1;
            KEY_OP2: op_num = OP_2;
            KEY_OP3: op_num = OP_3;
`ifdef CALC_BACKSPACE_EN
            KEY_OP4: is_bksp = 1'b1;
`else
            KEY_OP4: op_num = OP_4;
`endif
            default: op_num = OP_NONE;
        endcase
        // Operator keys beyond the enabled count behave as if never pressed.
        is_op   = (op_num != OP_NONE) && (int'(op_num) <= EFF_OPS);
        op_code = is_op ? op_num : OP_NONE;
    end

    assign is_digit = (key_code <= 4'd9);
    assign is_clr   = (key_code == KEY_CLR);
    assign is_equ   = (key_code == KEY_EQU);

endmodule

// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - operand-entry controller between key translator and ALU
//
// Ports:
//   clk, rst (sync, active low)
//   key_valid/key_code              decoded key strobe
//   calc_valid/calc_ready           A/op/B offer to the ALU
//   operand_a, operand_b, operator  operands and latched operator (0 = none)
//   result_valid/result_in          ALU result strobe
//   display_value, digit_count      operand being edited/shown and its digit count
//   digit_ovf                       one-cycle pulse when a digit is dropped
//   busy                            high while issuing or waiting for the ALU
//
// Optional build macro: CALC_BACKSPACE_EN enables backspace on 0xF in S_A/S_B.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int OP_W       = 14,
    parameter int NUM_OPS    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [3:0]      key_code,
    output logic            calc_valid,
    input  logic            calc_ready,
    output logic [OP_W-1:0] operand_a,
    output logic [OP_W-1:0] operand_b,
    output logic [2:0]      operator,
    input  logic            result_valid,
    input  logic [OP_W-1:0] result_in,
    output logic [OP_W-1:0] display_value,
    output logic [2:0]      digit_count,
    output logic            digit_ovf,
    output logic            busy
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    state_t     st;
    logic [2:0] a_cnt;  // digits of A, restored to digit_count when display returns to A

    logic       is_digit, is_op, is_clr, is_equ, is_bksp;
    logic [2:0] op_code;

    calc_key_class #(.NUM_OPS(NUM_OPS)) u_key_class (
        .key_code (key_code),
        .is_digit (is_digit),
        .is_op    (is_op),
        .op_code  (op_code),
        .is_clr   (is_clr),
        .is_equ   (is_equ),
        .is_bksp  (is_bksp)
    );

    function automatic logic [OP_W-1:0] shift_in(input logic [OP_W-1:0] v,
                                                 input logic [3:0] d);
        return OP_W'(v * OP_W'(10) + OP_W'(d));
    endfunction

    function automatic logic [OP_W-1:0] drop_last(input logic [OP_W-1:0] v);
        return v / OP_W'(10);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            st            <= S_A;
            a_cnt         <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            operator      <= OP_NONE;
            calc_valid    <= 1'b0;
            display_value <= '0;
            digit_count   <= '0;
            digit_ovf     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            digit_ovf <= 1'b0;
            // Clear wins over everything, including a same-cycle ALU handshake.
            if (key_valid && is_clr) begin
                st            <= S_A;
                a_cnt         <= '0;
                operand_a     <= '0;
                operand_b     <= '0;
                operator      <= OP_NONE;
                calc_valid    <= 1'b0;
                display_value <= '0;
                digit_count   <= '0;
                busy          <= 1'b0;
            end else begin
                case (st)
                    S_A: if (key_valid) begin
                        if (is_digit) begin
                            if (digit_count < MAX_CNT) begin
                                operand_a     <= shift_in(operand_a, key_code);
                                display_value <= shift_in(operand_a, key_code);
                                digit_count   <= digit_count + 3'd1;
                            end else begin
                                digit_ovf <= 1'b1;
                            end
                        end else if (is_op) begin
                            operator <= op_code;
                            a_cnt    <= digit_count;
                            st       <= S_OP;
                        end else if (is_bksp) begin
                            operand_a     <= drop_last(operand_a);
                            display_value <= drop_last(operand_a);
                            if (digit_count != 3'd0) digit_count <= digit_count - 3'd1;
                        end
                    end
                    S_OP: if (key_valid) begin
                        if (is_digit) begin
                            operand_b     <= OP_W'(key_code);
                            display_value <= OP_W'(key_code);
                            digit_count   <= 3'd1;
                            st            <= S_B;
                        end else if (is_op) begin
                            operator <= op_code;
                        end
                    end
                    S_B: if (key_valid) begin
                        if (is_digit) begin
                            if (digit_count < MAX_CNT) begin
                                operand_b     <= shift_in(operand_b, key_code);
                                display_value <= shift_in(operand_b, key_code);
                                digit_count   <= digit_count + 3'd1;
                            end else begin
                                digit_ovf <= 1'b1;
                            end
                        end else if (is_equ) begin
                            calc_valid    <= 1'b1;
                            busy          <= 1'b1;
                            display_value <= operand_a;
                            digit_count   <= a_cnt;
                            st            <= S_ISSUE;
                        end else if (is_bksp) begin
                            operand_b     <= drop_last(operand_b);
                            display_value <= drop_last(operand_b);
                            if (digit_count != 3'd0) digit_count <= digit_count - 3'd1;
                        end
                    end
                    S_ISSUE: if (calc_ready) begin
                        calc_valid <= 1'b0;
                        st         <= S_WAIT;
                    end
                    S_WAIT: if (result_valid) begin
                        operand_a     <= result_in;
                        display_value <= result_in;
                        operand_b     <= '0;
                        operator      <= OP_NONE;
                        digit_count   <= '0;
                        a_cnt         <= '0;
                        busy          <= 1'b0;
                        st            <= S_DONE;
                    end
                    S_DONE: if (key_valid) begin
                        if (is_digit) begin
                            operand_a     <= OP_W'(key_code);
                            display_value <= OP_W'(key_code);
                            digit_count   <= 3'd1;
                            st            <= S_A;
                        end else if (is_op) begin
                            // Chaining: the result stays in A as the left operand.
                            operator <= op_code;
                            a_cnt    <= digit_count;
                            st       <= S_OP;
                        end
                    end
                    default: st <= S_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - self-checking bench for calc_entry_fsm
module tb_calc_entry_fsm;

    localparam int MAX_DIGITS = 4;
    localparam int OP_W       = 14;
    localparam int NUM_OPS    = 2;
    localparam int MOD        = 1 << OP_W;
`ifdef CALC_BACKSPACE_EN
    localparam int EFF_OPS = (NUM_OPS > 3) ? 3 : NUM_OPS;
    localparam bit BKSP    = 1'b1;
`else
    localparam int EFF_OPS = NUM_OPS;
    localparam bit BKSP    = 1'b0;
`endif

    localparam int P_A = 0, P_OP = 1, P_B = 2, P_ISSUE = 3, P_WAIT = 4, P_DONE = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            key_valid = 1'b0;
    logic [3:0]      key_code = '0;
    logic            calc_ready = 1'b0;
    logic            result_valid = 1'b0;
    logic [OP_W-1:0] result_in = '0;
    logic            calc_valid;
    logic [OP_W-1:0] operand_a, operand_b, display_value;
    logic [2:0]      operator, digit_count;
    logic            digit_ovf, busy;

    int n_tests = 0;
    int n_fail  = 0;

    calc_entry_fsm #(.MAX_DIGITS(MAX_DIGITS), .OP_W(OP_W), .NUM_OPS(NUM_OPS)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .calc_valid    (calc_valid),
        .calc_ready    (calc_ready),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .operator      (operator),
        .result_valid  (result_valid),
        .result_in     (result_in),
        .display_value (display_value),
        .digit_count   (digit_count),
        .digit_ovf     (digit_ovf),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: operands held as lists of entered digits; a result
    // loaded from the ALU is a plain number with no digits behind it.
    int m_phase;
    int m_a[$];
    int m_b[$];
    int m_a_base;
    int m_op;
    bit m_ovf;

    function automatic int fold(input int q[$]);
        int v = 0;
        foreach (q[i]) v = (v * 10 + q[i]) % MOD;
        return v;
    endfunction

    function automatic int key_op(input logic [3:0] c);
        int n;
        case (c)
            4'hA: n = 1;
            4'hB: n = 2;
            4'hE: n = 3;
            4'hF: n = BKSP ? 0 : 4;
            default: n = 0;
        endcase
        return (n <= EFF_OPS) ? n : 0;
    endfunction

    function automatic int exp_a();
        return (m_a.size() == 0) ? m_a_base : fold(m_a);
    endfunction

    function automatic int exp_b();
        return fold(m_b);
    endfunction

    function automatic int exp_disp();
        return (m_phase == P_B) ? exp_b() : exp_a();
    endfunction

    function automatic int exp_cnt();
        return (m_phase == P_B) ? m_b.size() : m_a.size();
    endfunction

    task automatic model_clear();
        m_phase = P_A; m_a.delete(); m_b.delete(); m_a_base = 0; m_op = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit r, input bit kv, input logic [3:0] c,
                              input bit rdy, input bit rv, input int rin);
        bit dig, equ, bk;
        int opn;
        m_ovf = 0;
        if (!r || (kv && c == 4'hC)) begin
            model_clear();
            return;
        end
        dig = kv && (c <= 4'd9);
        equ = kv && (c == 4'hD);
        bk  = kv && BKSP && (c == 4'hF);
        opn = kv ? key_op(c) : 0;
        case (m_phase)
            P_A: begin
                if (dig) begin
                    if (m_a.size() < MAX_DIGITS) m_a.push_back(int'(c)); else m_ovf = 1;
                end else if (opn != 0) begin
                    m_op = opn; m_phase = P_OP;
                end else if (bk && m_a.size() > 0) m_a.pop_back();
            end
            P_OP: begin
                if (dig) begin
                    m_b.delete(); m_b.push_back(int'(c)); m_phase = P_B;
                end else if (opn != 0) m_op = opn;
            end
            P_B: begin
                if (dig) begin
                    if (m_b.size() < MAX_DIGITS) m_b.push_back(int'(c)); else m_ovf = 1;
                end else if (equ) m_phase = P_ISSUE;
                else if (bk && m_b.size() > 0) m_b.pop_back();
            end
            P_ISSUE: if (rdy) m_phase = P_WAIT;
            P_WAIT: if (rv) begin
                m_a.delete(); m_b.delete(); m_a_base = rin; m_op = 0; m_phase = P_DONE;
            end
            default: begin
                if (dig) begin
                    m_a_base = 0; m_a.delete(); m_a.push_back(int'(c)); m_phase = P_A;
                end else if (opn != 0) begin
                    m_op = opn; m_phase = P_OP;
                end
            end
        endcase
    endtask

    task automatic drive(input bit r, input bit kv, input logic [3:0] c,
                         input bit rdy, input bit rv, input int rin);
        @(negedge clk);
        rst = r; key_valid = kv; key_code = c; calc_ready = rdy;
        result_valid = rv; result_in = OP_W'(rin);
        model_step(r, kv, c, rdy, rv, rin);
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] c);
        drive(1, 1, c, 0, 0, 0);
    endtask

    task automatic idle(input bit rdy, input bit rv, input int rin);
        drive(1, 0, 4'h0, rdy, rv, rin);
    endtask

    task automatic test_reset();
        drive(0, 1, 4'h5, 1, 1, 123);
        drive(0, 1, 4'h7, 1, 1, 55);
        n_tests++;
        if ({operand_a, operand_b, operator, calc_valid, display_value, digit_count, digit_ovf, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%0d b=%0d op=%0d cv=%0b disp=%0d cnt=%0d ovf=%0b busy=%0b, required all 0",
                     operand_a, operand_b, operator, calc_valid, display_value, digit_count, digit_ovf, busy);
        end
    endtask

    task automatic test_basic_calc();
        drive(1, 1, 4'h1, 1, 0, 0);
        drive(1, 1, 4'h2, 1, 0, 0);
        drive(1, 1, 4'hA, 1, 0, 0);
        drive(1, 1, 4'h3, 1, 0, 0);
        drive(1, 1, 4'hD, 1, 0, 0);
        n_tests++;
        if (calc_valid !== 1'b1 || operand_a !== 14'd12 || operand_b !== 14'd3 || operator !== 3'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_issue: cv=%0b a=%0d b=%0d op=%0d busy=%0b, required cv=1 a=12 b=3 op=1 busy=1",
                     calc_valid, operand_a, operand_b, operator, busy);
        end
        idle(1, 0, 0);
        n_tests++;
        if (calc_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_accept: cv=%0b busy=%0b, required cv=0 busy=1", calc_valid, busy);
        end
        idle(0, 1, 15);
        n_tests++;
        if (display_value !== 14'd15 || operand_a !== 14'd15 || busy !== 1'b0 || operator !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_result: disp=%0d a=%0d busy=%0b op=%0d, required 15 15 0 0",
                     display_value, operand_a, busy, operator);
        end
    endtask

    task automatic test_digit_overflow();
        key(4'hC);
        for (int i = 0; i < 4; i++) key(4'h9);
        n_tests++;
        if (digit_ovf !== 1'b0 || operand_a !== 14'd9999 || digit_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_full: ovf=%0b a=%0d cnt=%0d, required 0 9999 4", digit_ovf, operand_a, digit_count);
        end
        key(4'h9);
        n_tests++;
        if (digit_ovf !== 1'b1 || operand_a !== 14'd9999 || digit_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_drop: ovf=%0b a=%0d cnt=%0d, required 1 9999 4", digit_ovf, operand_a, digit_count);
        end
        idle(0, 0, 0);
        n_tests++;
        if (digit_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pulse: ovf=%0b, required 0", digit_ovf);
        end
    endtask

    task automatic test_issue_stall();
        key(4'hC); key(4'h5); key(4'hA); key(4'hB); key(4'h7); key(4'hD);
        n_tests++;
        if (operator !== 3'd2 || calc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_op: op=%0d cv=%0b, required op=2 cv=1", operator, calc_valid);
        end
        for (int i = 0; i < 3; i++) begin
            idle(0, 0, 0);
            n_tests++;
            if (calc_valid !== 1'b1 || operand_a !== 14'd5 || operand_b !== 14'd7 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: cv=%0b a=%0d b=%0d busy=%0b, required 1 5 7 1",
                         i, calc_valid, operand_a, operand_b, busy);
            end
        end
        idle(1, 0, 0);
        n_tests++;
        if (calc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: cv=%0b, required 0", calc_valid);
        end
        idle(0, 1, 15);
    endtask

    task automatic test_chaining();
        key(4'hB); key(4'h2); key(4'hD);
        n_tests++;
        if (operand_a !== 14'd15 || operand_b !== 14'd2 || operator !== 3'd2 || calc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL chain_issue: a=%0d b=%0d op=%0d cv=%0b, required 15 2 2 1",
                     operand_a, operand_b, operator, calc_valid);
        end
        idle(1, 0, 0);
        idle(0, 1, 17);
        key(4'h4);
        n_tests++;
        if (operand_a !== 14'd4 || digit_count !== 3'd1 || display_value !== 14'd4) begin
            n_fail++;
            $display("FAIL chain_new: a=%0d cnt=%0d disp=%0d, required 4 1 4", operand_a, digit_count, display_value);
        end
    endtask

    task automatic test_clear_with_ready();
        key(4'hC); key(4'h1); key(4'hA); key(4'h2); key(4'hD);
        drive(1, 1, 4'hC, 1, 0, 0);
        n_tests++;
        if (calc_valid !== 1'b0 || operand_a !== 14'd0 || busy !== 1'b0 || operator !== 3'd0) begin
            n_fail++;
            $display("FAIL clr_ready: cv=%0b a=%0d busy=%0b op=%0d, required 0 0 0 0",
                     calc_valid, operand_a, busy, operator);
        end
        idle(0, 1, 77);
        n_tests++;
        if (operand_a !== 14'd0 || display_value !== 14'd0) begin
            n_fail++;
            $display("FAIL clr_result_ignored: a=%0d disp=%0d, required 0 0", operand_a, display_value);
        end
        key(4'hE);
        n_tests++;
        if (operator !== 3'd0) begin
            n_fail++;
            $display("FAIL op_disabled: op=%0d, required 0", operator);
        end
        key(4'h6);
        n_tests++;
        if (operand_a !== 14'd6 || display_value !== 14'd6) begin
            n_fail++;
            $display("FAIL op_disabled_state: a=%0d disp=%0d, required 6 6", operand_a, display_value);
        end
    endtask

    task automatic test_reset_mid_entry();
        key(4'hC); key(4'h3); key(4'h4); key(4'hA); key(4'h5);
        drive(0, 0, 4'h0, 0, 0, 0);
        n_tests++;
        if ({operand_a, operand_b, operator, calc_valid, display_value, digit_count, digit_ovf, busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: a=%0d b=%0d op=%0d disp=%0d cnt=%0d, required all 0",
                     operand_a, operand_b, operator, display_value, digit_count);
        end
        key(4'h7);
        n_tests++;
        if (operand_a !== 14'd7 || digit_count !== 3'd1) begin
            n_fail++;
            $display("FAIL rst_mid_state: a=%0d cnt=%0d, required 7 1", operand_a, digit_count);
        end
    endtask

`ifdef CALC_BACKSPACE_EN
    task automatic test_backspace();
        key(4'hC); key(4'h3); key(4'h4); key(4'hF);
        n_tests++;
        if (operand_a !== 14'd3 || digit_count !== 3'd1) begin
            n_fail++;
            $display("FAIL backspace: a=%0d cnt=%0d, required 3 1", operand_a, digit_count);
        end
    endtask
`endif

    task automatic test_random();
        int ea;
        key(4'hC);
        for (int i = 0; i < 600; i++) begin
            drive(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, MOD - 1));
            ea = exp_a();
            n_tests++;
            if (operand_a !== OP_W'(ea)) begin
                n_fail++; $display("FAIL rnd_a[%0d]: got %0d required %0d", i, operand_a, ea);
            end
            n_tests++;
            if (operand_b !== OP_W'(exp_b())) begin
                n_fail++; $display("FAIL rnd_b[%0d]: got %0d required %0d", i, operand_b, exp_b());
            end
            n_tests++;
            if (operator !== 3'(m_op)) begin
                n_fail++; $display("FAIL rnd_op[%0d]: got %0d required %0d", i, operator, m_op);
            end
            n_tests++;
            if (calc_valid !== (m_phase == P_ISSUE)) begin
                n_fail++; $display("FAIL rnd_cv[%0d]: got %0b required %0b", i, calc_valid, m_phase == P_ISSUE);
            end
            n_tests++;
            if (busy !== (m_phase == P_ISSUE || m_phase == P_WAIT)) begin
                n_fail++; $display("FAIL rnd_busy[%0d]: got %0b required %0b", i, busy,
                                   m_phase == P_ISSUE || m_phase == P_WAIT);
            end
            n_tests++;
            if (display_value !== OP_W'(exp_disp())) begin
                n_fail++; $display("FAIL rnd_disp[%0d]: got %0d required %0d", i, display_value, exp_disp());
            end
            n_tests++;
            if (digit_count !== 3'(exp_cnt())) begin
                n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d required %0d", i, digit_count, exp_cnt());
            end
            n_tests++;
            if (digit_ovf !== m_ovf) begin
                n_fail++; $display("FAIL rnd_ovf[%0d]: got %0b required %0b", i, digit_ovf, m_ovf);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_calc();
        test_digit_overflow();
        test_issue_stall();
        test_chaining();
        test_clear_with_ready();
        test_reset_mid_entry();
`ifdef CALC_BACKSPACE_EN
        test_backspace();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Sequential operand-entry controller for the keypad calculator.
- Consumes decoded key strobes from the keypad translator.
- Accumulates decimal digits into binary operands A and B, and latches the operator.
- Issues A/op/B to the ALU with a valid/ready handshake, then reloads A from the ALU result so operations can be chained. Sits between the key translator and the ALU/display path.

Parameters:
- MAX_DIGITS, 4: maximum decimal digits per operand.
- OP_W, 14: operand/result width in bits. Must satisfy 10^MAX_DIGITS - 1 < 2^OP_W.
- NUM_OPS, 2: number of operator keys enabled (1..4).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- key_valid  in  1  single-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0x0-0x9 digit; 0xA, 0xB, 0xE, 0xF operators 1-4; 0xC clear; 0xD equals.
- calc_valid  out  1  A/op/B offered to the ALU.
- calc_ready  in  1  ALU accepts when calc_valid & calc_ready.
- operand_a  out  OP_W  operand A.
- operand_b  out  OP_W  operand B.
- operator  out  3  latched operator code, 1..NUM_OPS; 0 = none.
- result_valid  in  1  ALU result strobe.
- result_in  in  OP_W  ALU result.
- display_value  out  OP_W  operand currently being edited or shown.
- digit_count  out  3  digits entered in the current operand.
- digit_ovf  out  1  one-cycle pulse when a digit is dropped because the operand is full.
- busy  out  1  high in S_ISSUE and S_WAIT.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - State goes to S_A.
  - All outputs go to 0, including operand_a, operand_b, operator, calc_valid, digit_count and display_value.
- Key classes:
  - Digit: code 0-9.
  - Op: 0xA→1, 0xB→2, 0xE→3, 0xF→4. An op key whose number exceeds NUM_OPS is ignored.
  - Clear: 0xC.
  - Equals: 0xD.
- Keys are acted on only on cycles where key_valid = 1.
- Digit accumulation: value = value*10 + d, computed in OP_W bits.
  - Applies only when digit_count < MAX_DIGITS; digit_count then increments.
  - Otherwise the digit is dropped and digit_ovf pulses for one cycle.
- States:
  - S_A:
    - Digit: accumulate into A.
    - Op: latch operator, go to S_OP.
    - Equals: ignored.
  - S_OP:
    - Op: replace the latched operator.
    - Digit: B = d, digit_count = 1, go to S_B.
    - Equals: ignored.
  - S_B:
    - Digit: accumulate into B.
    - Op: ignored.
    - Equals: go to S_ISSUE; calc_valid = 1 from the next cycle.
  - S_ISSUE:
    - calc_valid is held high, with operand_a, operand_b and operator stable, until calc_ready = 1.
    - On that cycle the transfer completes; go to S_WAIT and drop calc_valid.
    - Non-clear keys are ignored.
  - S_WAIT:
    - On result_valid: A = result_in, B = 0, operator = 0, digit_count = 0, go to S_DONE.
    - Non-clear keys are ignored.
  - S_DONE:
    - Digit: A = d, digit_count = 1, go to S_A (new calculation).
    - Op: keep A (chaining), latch operator, go to S_OP.
    - Equals: ignored.
- Clear, in any state:
  - Next cycle: A = B = 0, operator = 0, digit_count = 0, calc_valid = 0, state S_A.
  - Clear takes priority over every other event in the same cycle.
  - Clear together with calc_ready: the transfer counts as done, but the FSM goes to S_A, and any later result_valid is ignored (result_valid is ignored outside S_WAIT).
- display_value:
  - Shows B in S_B.
  - Shows A in every other state.
- digit_count tracks whichever operand display_value shows.
- Latency: key to register update is 1 cycle. Equals to calc_valid is 1 cycle.

Optional Feature:
- Macro: CALC_BACKSPACE_EN.
- When defined:
  - 0xF is a backspace key in S_A and S_B: value = value/10, digit_count decrements with a floor of 0.
  - Backspace is ignored in the other states.
  - The effective NUM_OPS is clamped to 3.
- When not defined: 0xF is operator 4 (subject to NUM_OPS), and there is no backspace.

Decomposition:
- Package calc_pkg holds:
  - The state enum (S_A, S_OP, S_B, S_ISSUE, S_WAIT, S_DONE).
  - Key code constants (KEY_CLR = 0xC, KEY_EQU = 0xD, op key codes).
  - Operator code constants.
- One natural sub-module: calc_key_class, a combinational classifier of key_code into is_digit, is_op, op_code, is_clr, is_equ and is_bksp, parametrised by NUM_OPS.

Test Plan:
- Keys 1,2,A,3,D with calc_ready = 1 → calc_valid pulses one cycle with operand_a = 12, operand_b = 3, operator = 1; result_in = 15 on result_valid → display_value = 15, state S_DONE.
- Keys 9,9,9,9,9 (MAX_DIGITS = 4) → operand_a = 9999, digit_count = 4, digit_ovf pulses once on the fifth key.
- Keys 5,A,B,7,D, then calc_ready held low for 3 cycles → operator = 2, calc_valid stays high with stable operands for 4 cycles, busy = 1.
- In S_DONE with A = 15: key B, 2, D → operand_a = 15, operand_b = 2, operator = 2. In S_DONE: key 4 → operand_a = 4.
- Clear in the same cycle as calc_ready, then result_valid with 77 → state S_A, operand_a = 0, the result is ignored. Key 0xE with NUM_OPS = 2 → no change.
- rst low mid-entry (A = 34, state S_B) → all outputs 0 and state S_A next cycle. With CALC_BACKSPACE_EN: keys 3,4,F → operand_a = 3, digit_count = 1.
